// File: rtl/gw_video_pkg.sv
// Shared video-block definitions: default segment geometry, counter sizing
// helper and the persistence sweep state encoding.
package gw_video_pkg;

    localparam int MAX_X_SEGMENT_DEF = 9;
    localparam int MAX_Y_SEGMENT_DEF = 16;
    localparam int MAX_Z_SEGMENT_DEF = 4;

    // Width needed to hold a life counter loaded with decay_frames.
    function automatic int cnt_w(input int decay_frames);
        return $clog2(decay_frames + 1);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_PUBLISH
    } sweep_state_t;

endpackage

// File: rtl/segment_persistence_if.sv
// CPU multiplexed LCD drive bus: one strobe carries a line, its column bits
// and the active H rows.
interface segment_persistence_if #(
    parameter int MAX_Y_SEGMENT = 16,
    parameter int MAX_Z_SEGMENT = 4
);
    logic                     seg_strobe;
    logic [3:0]               seg_line;
    logic [MAX_Y_SEGMENT-1:0] seg_columns;
    logic [MAX_Z_SEGMENT-1:0] seg_rows;

    modport master (
        output seg_strobe,
        output seg_line,
        output seg_columns,
        output seg_rows
    );

    modport slave (
        input seg_strobe,
        input seg_line,
        input seg_columns,
        input seg_rows
    );
endinterface

// File: rtl/segment_life_line.sv
// One segment line: Y x Z life counters with strobe reload, per-frame aging
// and the shadow bits that feed the published snapshot.
module segment_life_line #(
    parameter int MAX_Y_SEGMENT = 16,
    parameter int MAX_Z_SEGMENT = 4,
    parameter int DECAY_FRAMES  = 3,
    parameter int CNT_W         = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     load_en,
    input  logic                     sweep_en,
    input  logic [MAX_Y_SEGMENT-1:0] columns,
    input  logic [MAX_Z_SEGMENT-1:0] rows,
    output logic [MAX_Z_SEGMENT-1:0] shadow [MAX_Y_SEGMENT]
);
    localparam logic [CNT_W-1:0] LIFE_FULL  = CNT_W'(DECAY_FRAMES);
    localparam logic [CNT_W-1:0] LIFE_SWEPT = CNT_W'(DECAY_FRAMES - 1);

    for (genvar gi = 0; gi < MAX_Y_SEGMENT; gi++) begin : g_col
        logic [CNT_W-1:0]         life_q [MAX_Z_SEGMENT];
        logic [CNT_W-1:0]         life_d [MAX_Z_SEGMENT];
        logic [MAX_Z_SEGMENT-1:0] shadow_q, shadow_d;

        // A strobe landing on the line being swept counts as already aged once.
        always_comb begin
            shadow_d = shadow_q;
            for (int z = 0; z < MAX_Z_SEGMENT; z++) begin
                life_d[z] = life_q[z];
                if (clear) begin
                    life_d[z]   = '0;
                    shadow_d[z] = 1'b0;
                end else if (sweep_en) begin
                    shadow_d[z] = (life_q[z] != '0) | (load_en & columns[gi] & rows[z]);
                    if (load_en & columns[gi] & rows[z]) begin
                        life_d[z] = LIFE_SWEPT;
                    end else if (life_q[z] != '0) begin
                        life_d[z] = life_q[z] - 1'b1;
                    end
                end else if (load_en & columns[gi] & rows[z]) begin
                    life_d[z] = LIFE_FULL;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                shadow_q <= '0;
                for (int z = 0; z < MAX_Z_SEGMENT; z++) begin
                    life_q[z] <= '0;
                end
            end else begin
                shadow_q <= shadow_d;
                for (int z = 0; z < MAX_Z_SEGMENT; z++) begin
                    life_q[z] <= life_d[z];
                end
            end
        end

        assign shadow[gi] = shadow_q;
    end

endmodule

// File: rtl/segment_persistence.sv
// LCD persistence model: CPU strobes reload per-segment life counters; a
// vblank-triggered sweep ages them and publishes a frame-stable snapshot.
module segment_persistence
    import gw_video_pkg::*;
#(
    parameter int MAX_X_SEGMENT = MAX_X_SEGMENT_DEF,
    parameter int MAX_Y_SEGMENT = MAX_Y_SEGMENT_DEF,
    parameter int MAX_Z_SEGMENT = MAX_Z_SEGMENT_DEF,
    parameter int DECAY_FRAMES  = 3,
    parameter int CNT_W         = cnt_w(DECAY_FRAMES)
) (
    input  logic                     clk,
    input  logic                     reset,
    segment_persistence_if.slave     seg_bus,
    input  logic                     clear,
    input  logic                     vblank,
    output logic [MAX_Z_SEGMENT-1:0] segments [MAX_X_SEGMENT][MAX_Y_SEGMENT],
    output logic                     sweep_busy
);
    localparam int K_W = (MAX_X_SEGMENT > 1) ? $clog2(MAX_X_SEGMENT) : 1;

    sweep_state_t             state_q, state_d;
    logic [K_W-1:0]           k_q, k_d;
    logic                     vblank_q, vblank_d;
    logic                     vblank_edge;
    logic                     line_valid;
    logic [MAX_Z_SEGMENT-1:0] shadow_all [MAX_X_SEGMENT][MAX_Y_SEGMENT];
    logic [MAX_Z_SEGMENT-1:0] segments_q [MAX_X_SEGMENT][MAX_Y_SEGMENT];
    logic [MAX_Z_SEGMENT-1:0] segments_d [MAX_X_SEGMENT][MAX_Y_SEGMENT];

    assign vblank_d    = vblank;
    assign vblank_edge = vblank & ~vblank_q;
    assign line_valid  = int'(seg_bus.seg_line) < MAX_X_SEGMENT;
    assign sweep_busy  = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        if (clear) begin
            state_d = ST_IDLE;
            k_d     = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (vblank_edge) begin
                        state_d = ST_SWEEP;
                        k_d     = '0;
                    end
                end
                ST_SWEEP: begin
                    if (int'(k_q) == MAX_X_SEGMENT - 1) begin
                        state_d = ST_PUBLISH;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                ST_PUBLISH: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // The snapshot only moves at the end of PUBLISH, so active video never
    // sees a half-swept frame.
    always_comb begin
        segments_d = segments_q;
        if (clear) begin
            for (int x = 0; x < MAX_X_SEGMENT; x++) begin
                for (int y = 0; y < MAX_Y_SEGMENT; y++) begin
                    segments_d[x][y] = '0;
                end
            end
        end else if (state_q == ST_PUBLISH) begin
            segments_d = shadow_all;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            vblank_q <= 1'b0;
            for (int x = 0; x < MAX_X_SEGMENT; x++) begin
                for (int y = 0; y < MAX_Y_SEGMENT; y++) begin
                    segments_q[x][y] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            vblank_q   <= vblank_d;
            segments_q <= segments_d;
        end
    end

    assign segments = segments_q;

    for (genvar gi = 0; gi < MAX_X_SEGMENT; gi++) begin : g_line
        logic load_en;
        logic sweep_en;

        assign load_en  = seg_bus.seg_strobe & line_valid & (int'(seg_bus.seg_line) == gi);
        assign sweep_en = (state_q == ST_SWEEP) & (int'(k_q) == gi);

        segment_life_line #(
            .MAX_Y_SEGMENT (MAX_Y_SEGMENT),
            .MAX_Z_SEGMENT (MAX_Z_SEGMENT),
            .DECAY_FRAMES  (DECAY_FRAMES),
            .CNT_W         (CNT_W)
        ) u_line (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .load_en  (load_en),
            .sweep_en (sweep_en),
            .columns  (seg_bus.seg_columns),
            .rows     (seg_bus.seg_rows),
            .shadow   (shadow_all[gi])
        );
    end

endmodule

// File: tb/tb_segment_persistence.sv
// Directed bench for segment_persistence: frame-by-frame expected snapshots
// and sweep_busy lengths written out by hand.
module tb_segment_persistence;
    localparam int NX = 9;
    localparam int NY = 16;
    localparam int NZ = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          vblank;
    logic          sweep_busy;
    logic [NZ-1:0] segments [NX][NY];

    logic [NZ-1:0] exp_cur [NX][NY];
    logic [NZ-1:0] exp_nxt [NX][NY];

    int checks   = 0;
    int failures = 0;

    segment_persistence_if #(.MAX_Y_SEGMENT(NY), .MAX_Z_SEGMENT(NZ)) bus ();

    segment_persistence dut (
        .clk        (clk),
        .reset      (reset),
        .seg_bus    (bus),
        .clear      (clear),
        .vblank     (vblank),
        .segments   (segments),
        .sweep_busy (sweep_busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic zero_nxt;
        for (int x = 0; x < NX; x++)
            for (int y = 0; y < NY; y++)
                exp_nxt[x][y] = '0;
    endtask

    task automatic check_segs(input string tag, input logic [NZ-1:0] e [NX][NY]);
        int diffs;
        int fx;
        int fy;
        diffs = 0;
        fx    = 0;
        fy    = 0;
        for (int x = 0; x < NX; x++) begin
            for (int y = 0; y < NY; y++) begin
                if (segments[x][y] !== e[x][y]) begin
                    if (diffs == 0) begin
                        fx = x;
                        fy = y;
                    end
                    diffs++;
                end
            end
        end
        checks++;
        assert (diffs === 0) else begin
            failures++;
            $error("FAIL %s: %0d cells differ, first [%0d][%0d] got %b expected %b",
                   tag, diffs, fx, fy, segments[fx][fy], e[fx][fy]);
        end
    endtask

    task automatic check_val(input string tag, input int got, input int want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic strobe_cycle(input logic [3:0] line, input logic [15:0] cols,
                                input logic [3:0] rows);
        bus.seg_strobe  = 1'b1;
        bus.seg_line    = line;
        bus.seg_columns = cols;
        bus.seg_rows    = rows;
        tick;
        bus.seg_strobe  = 1'b0;
    endtask

    // Cycle c=0 is the vblank edge cycle E; a strobe/clear may be placed at E+st_off / E+clr_off.
    task automatic run_frame(input string tag, input int exp_busy, input int st_off,
                             input logic [3:0] st_line, input logic [15:0] st_cols,
                             input logic [3:0] st_rows, input int clr_off);
        int busy_n;
        busy_n = 0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                if (!sweep_busy) break;
                busy_n++;
                if (c == 10) check_segs({tag, " hold"}, exp_cur);
            end
            vblank          = (c == 0);
            bus.seg_strobe  = (c == st_off);
            bus.seg_line    = st_line;
            bus.seg_columns = st_cols;
            bus.seg_rows    = st_rows;
            clear           = (c == clr_off);
            tick;
        end
        vblank         = 1'b0;
        bus.seg_strobe = 1'b0;
        clear          = 1'b0;
        check_val({tag, " busy"}, busy_n, exp_busy);
        check_segs({tag, " pub"}, exp_nxt);
        $display("frame %s: busy=%0d", tag, busy_n);
        exp_cur = exp_nxt;
    endtask

    initial begin
        reset           = 1'b1;
        clear           = 1'b0;
        vblank          = 1'b0;
        bus.seg_strobe  = 1'b0;
        bus.seg_line    = '0;
        bus.seg_columns = '0;
        bus.seg_rows    = '0;
        zero_nxt;
        exp_cur = exp_nxt;
        tick;
        tick;
        check_segs("reset segs", exp_cur);
        check_val("reset busy", int'(sweep_busy), 0);
        reset = 1'b0;
        tick;

        // Idle frames: nothing ever published.
        for (int f = 0; f < 3; f++) run_frame("idle", 10, -1, 4'd0, 16'h0, 4'h0, -1);

        // Line 2 strobed before the frame: visible for three frames.
        strobe_cycle(4'd2, 16'h0005, 4'h1);
        exp_nxt[2][0] = 4'b0001;
        exp_nxt[2][2] = 4'b0001;
        run_frame("l2 f1", 10, -1, 4'd0, 16'h0, 4'h0, -1);
        check_val("l2 bit", int'(segments[2][0][0]), 1);
        run_frame("l2 f2", 10, -1, 4'd0, 16'h0, 4'h0, -1);
        run_frame("l2 f3", 10, -1, 4'd0, 16'h0, 4'h0, -1);
        zero_nxt;
        run_frame("l2 f4", 10, -1, 4'd0, 16'h0, 4'h0, -1);

        // Line 4 strobed while it is being swept (E+5): published in this frame.
        exp_nxt[4][0] = 4'b0010;
        run_frame("l4 f1", 10, 5, 4'd4, 16'h0001, 4'h2, -1);
        run_frame("l4 f2 line12", 10, 0, 4'd12, 16'hFFFF, 4'hF, -1);
        run_frame("l4 f3 pubstrobe", 10, 10, 4'd0, 16'h8000, 4'h8, -1);
        exp_nxt[4][0]  = 4'b0000;
        exp_nxt[0][15] = 4'b1000;
        run_frame("l4 f4", 10, -1, 4'd0, 16'h0, 4'h0, -1);

        // Clear at E+3 with a simultaneous strobe; cleared life must not return.
        zero_nxt;
        run_frame("clear", 3, 3, 4'd5, 16'h0001, 4'h1, 3);
        run_frame("post clear", 10, -1, 4'd0, 16'h0, 4'h0, -1);

        // Reset mid-sweep after content is shown.
        strobe_cycle(4'd6, 16'h0010, 4'h4);
        exp_nxt[6][4] = 4'b0100;
        run_frame("l6", 10, -1, 4'd0, 16'h0, 4'h0, -1);
        vblank = 1'b1;
        tick;
        vblank = 1'b0;
        tick;
        tick;
        check_val("pre reset busy", int'(sweep_busy), 1);
        #2;
        reset = 1'b1;
        #1;
        zero_nxt;
        exp_cur = exp_nxt;
        check_segs("async reset segs", exp_cur);
        check_val("async reset busy", int'(sweep_busy), 0);
        tick;
        tick;
        reset = 1'b0;
        tick;
        exp_nxt[0][1] = 4'b0001;
        run_frame("after reset", 10, 1, 4'd0, 16'h0002, 4'h1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
